// File: rtl/c64_ps2_keyboard.sv
// PS/2 set-2 keyboard to C64 CIA#1 8x8 key matrix; optional ghosting model via `KBD_GHOST_EN.
// Latency: key state updates 1 cycle after a byte is accepted; sense outputs registered 1 cycle after inputs.
// Backpressure: none; PS/2 is device-clocked and every accepted byte is consumed immediately.
module c64_ps2_keyboard #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] col_n,
    input  logic [7:0] row_n,
    output logic [7:0] row_sense_n,
    output logic [7:0] col_sense_n,
    output logic       restore_n,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, EXT, REL, EXTREL} dec_state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, clk_fall;
    logic [FW-1:0] filt_cnt;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          byte_valid;
    logic [7:0]    rx_byte;
    dec_state_t    state;
    logic [7:0][7:0] key_q;   // key_q[col][row]
    logic          is_ext, is_rel, is_special;
    logic [6:0]    map_hit;
    logic [7:0]    eff_col, eff_row, row_nxt, col_nxt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                clk_fall <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // After ten shifts shreg holds {parity, data[7:0], start}; the stop bit is sampled live.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (clk_fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!shreg[0] && data_sync[1] && (^shreg[9:1])) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Returns {hit, col[2:0], row[2:0]} for a scan code.
    function automatic logic [6:0] key_map(input logic [7:0] code, input logic ext);
        logic [6:0] m;
        m = 7'd0;
        if (ext) begin
            case (code)
                8'h74: m = {1'b1, 3'd0, 3'd2};
                8'h72: m = {1'b1, 3'd0, 3'd7};
                8'h5A: m = {1'b1, 3'd0, 3'd1};
                8'h6C: m = {1'b1, 3'd6, 3'd3};
                default: m = 7'd0;
            endcase
        end else begin
            case (code)
                8'h66: m = {1'b1, 3'd0, 3'd0};
                8'h5A: m = {1'b1, 3'd0, 3'd1};
                8'h83: m = {1'b1, 3'd0, 3'd3};
                8'h05: m = {1'b1, 3'd0, 3'd4};
                8'h04: m = {1'b1, 3'd0, 3'd5};
                8'h03: m = {1'b1, 3'd0, 3'd6};
                8'h26: m = {1'b1, 3'd1, 3'd0};
                8'h1D: m = {1'b1, 3'd1, 3'd1};
                8'h1C: m = {1'b1, 3'd1, 3'd2};
                8'h25: m = {1'b1, 3'd1, 3'd3};
                8'h1A: m = {1'b1, 3'd1, 3'd4};
                8'h1B: m = {1'b1, 3'd1, 3'd5};
                8'h24: m = {1'b1, 3'd1, 3'd6};
                8'h12: m = {1'b1, 3'd1, 3'd7};
                8'h2E: m = {1'b1, 3'd2, 3'd0};
                8'h2D: m = {1'b1, 3'd2, 3'd1};
                8'h23: m = {1'b1, 3'd2, 3'd2};
                8'h36: m = {1'b1, 3'd2, 3'd3};
                8'h21: m = {1'b1, 3'd2, 3'd4};
                8'h2B: m = {1'b1, 3'd2, 3'd5};
                8'h2C: m = {1'b1, 3'd2, 3'd6};
                8'h22: m = {1'b1, 3'd2, 3'd7};
                8'h3D: m = {1'b1, 3'd3, 3'd0};
                8'h35: m = {1'b1, 3'd3, 3'd1};
                8'h34: m = {1'b1, 3'd3, 3'd2};
                8'h3E: m = {1'b1, 3'd3, 3'd3};
                8'h32: m = {1'b1, 3'd3, 3'd4};
                8'h33: m = {1'b1, 3'd3, 3'd5};
                8'h3C: m = {1'b1, 3'd3, 3'd6};
                8'h2A: m = {1'b1, 3'd3, 3'd7};
                8'h46: m = {1'b1, 3'd4, 3'd0};
                8'h43: m = {1'b1, 3'd4, 3'd1};
                8'h3B: m = {1'b1, 3'd4, 3'd2};
                8'h45: m = {1'b1, 3'd4, 3'd3};
                8'h3A: m = {1'b1, 3'd4, 3'd4};
                8'h42: m = {1'b1, 3'd4, 3'd5};
                8'h44: m = {1'b1, 3'd4, 3'd6};
                8'h31: m = {1'b1, 3'd4, 3'd7};
                8'h4E: m = {1'b1, 3'd5, 3'd0};
                8'h4D: m = {1'b1, 3'd5, 3'd1};
                8'h4B: m = {1'b1, 3'd5, 3'd2};
                8'h55: m = {1'b1, 3'd5, 3'd3};
                8'h49: m = {1'b1, 3'd5, 3'd4};
                8'h4C: m = {1'b1, 3'd5, 3'd5};
                8'h54: m = {1'b1, 3'd5, 3'd6};
                8'h41: m = {1'b1, 3'd5, 3'd7};
                8'h5D: m = {1'b1, 3'd6, 3'd0};
                8'h5B: m = {1'b1, 3'd6, 3'd1};
                8'h52: m = {1'b1, 3'd6, 3'd2};
                8'h59: m = {1'b1, 3'd6, 3'd4};
                8'h4A: m = {1'b1, 3'd6, 3'd7};
                8'h16: m = {1'b1, 3'd7, 3'd0};
                8'h0E: m = {1'b1, 3'd7, 3'd1};
                8'h14: m = {1'b1, 3'd7, 3'd2};
                8'h1E: m = {1'b1, 3'd7, 3'd3};
                8'h29: m = {1'b1, 3'd7, 3'd4};
                8'h11: m = {1'b1, 3'd7, 3'd5};
                8'h15: m = {1'b1, 3'd7, 3'd6};
                8'h76: m = {1'b1, 3'd7, 3'd7};
                default: m = 7'd0;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        is_ext     = (state == EXT) || (state == EXTREL);
        is_rel     = (state == REL) || (state == EXTREL);
        is_special = (rx_byte == 8'hE1) || (rx_byte == 8'hAA) || (rx_byte == 8'hFC) ||
                     (rx_byte == 8'hFE) || (rx_byte == 8'hFA) || (rx_byte == 8'hEE);
        map_hit    = key_map(rx_byte, is_ext);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            key_q     <= '0;
            restore_n <= 1'b1;
        end else if (byte_valid) begin
            if (is_special) begin
                if (rx_byte == 8'hAA && state == IDLE) begin
                    key_q     <= '0;
                    restore_n <= 1'b1;
                end
            end else if (state == IDLE && rx_byte == 8'hE0) begin
                state <= EXT;
            end else if ((state == IDLE || state == EXT) && rx_byte == 8'hF0) begin
                state <= (state == EXT) ? EXTREL : REL;
            end else begin
                state <= IDLE;
                if (map_hit[6])
                    key_q[map_hit[5:3]][map_hit[2:0]] <= ~is_rel;
                if (!is_ext && rx_byte == 8'h07)
                    restore_n <= is_rel;
            end
        end
    end

    always_comb begin
        eff_col = ~col_n;
        eff_row = ~row_n;
`ifdef KBD_GHOST_EN
        // One ghost level: a column sharing a pressed-key row with a selected column is pulled low too.
        begin
            logic [7:0] rows_hit, cols_hit;
            rows_hit = '0;
            cols_hit = '0;
            for (int c = 0; c < 8; c++)
                for (int r = 0; r < 8; r++) begin
                    rows_hit[r] = rows_hit[r] | (key_q[c][r] & ~col_n[c]);
                    cols_hit[c] = cols_hit[c] | (key_q[c][r] & ~row_n[r]);
                end
            for (int c = 0; c < 8; c++)
                for (int r = 0; r < 8; r++) begin
                    eff_col[c] = eff_col[c] | (key_q[c][r] & rows_hit[r]);
                    eff_row[r] = eff_row[r] | (key_q[c][r] & cols_hit[c]);
                end
        end
`else
`endif
        row_nxt = 8'hFF;
        col_nxt = 8'hFF;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) begin
                if (key_q[c][r] & eff_col[c]) row_nxt[r] = 1'b0;
                if (key_q[c][r] & eff_row[r]) col_nxt[c] = 1'b0;
            end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            row_sense_n <= 8'hFF;
            col_sense_n <= 8'hFF;
        end else begin
            row_sense_n <= row_nxt;
            col_sense_n <= col_nxt;
        end
    end

endmodule

// File: tb/tb_c64_ps2_keyboard.sv
// Directed bench for c64_ps2_keyboard: PS/2 frames in, CIA matrix sense lines checked.
module tb_c64_ps2_keyboard;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] col_n = 8'hFF;
    logic [7:0] row_n = 8'hFF;
    logic [7:0] row_sense_n, col_sense_n;
    logic       restore_n, frame_err;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    c64_ps2_keyboard dut (
        .clk(clk), .res_n(res_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .col_n(col_n), .row_n(row_n), .row_sense_n(row_sense_n),
        .col_sense_n(col_sense_n), .restore_n(restore_n), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_pulses++;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(frame(b, 1'b0), 11);
    endtask

    initial begin
        wait_cyc(3);
        check("rst_row", row_sense_n, 8'hFF);
        check("rst_col", col_sense_n, 8'hFF);
        check("rst_restore", {7'd0, restore_n}, 8'h01);
        check("rst_ferr", {7'd0, frame_err}, 8'h00);
        res_n = 1'b1;
        wait_cyc(5);

        col_n = 8'hFD;
        send(8'h1C);
        check("a_col1", row_sense_n, 8'hFB);
        col_n = 8'hFE;
        wait_cyc(2);
        check("a_col0", row_sense_n, 8'hFF);
        col_n = 8'h00;
        wait_cyc(2);
        check("a_all", row_sense_n, 8'hFB);
        send(8'hF0); send(8'h1C);
        check("a_rel", row_sense_n, 8'hFF);
        check_int("no_ferr", err_pulses, 0);

        col_n = 8'hFD;
        send(8'h1C); send(8'h1C);
        check("a_twice", row_sense_n, 8'hFB);
        send(8'hF0); send(8'hFA); send(8'h1C);
        check("a_rel_fa", row_sense_n, 8'hFF);

        col_n = 8'h00;
        send_bits(frame(8'h1C, 1'b1), 11);
        check_int("bad_par_ferr", err_pulses, 1);
        check("bad_par_row", row_sense_n, 8'hFF);
        send_bits(frame(8'h1C, 1'b0), 6);
        wait_cyc(16400);
        send(8'h5A);
        col_n = 8'hFE;
        wait_cyc(2);
        check("ret_after_to", row_sense_n, 8'hFD);
        check_int("to_no_ferr", err_pulses, 1);

        send(8'hF0); send(8'h5A);
        check("ret_rel", row_sense_n, 8'hFF);
        send(8'hE0); send(8'h74);
        send(8'h07);
        check("crsr_rt", row_sense_n, 8'hFB);
        check("restore_lo", {7'd0, restore_n}, 8'h00);
        send(8'hF0); send(8'h07);
        check("restore_hi", {7'd0, restore_n}, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("crsr_rel", row_sense_n, 8'hFF);

        send(8'h12); send(8'h5A);
        row_n = 8'h7F;
        wait_cyc(2);
        check("rev_r7", col_sense_n, 8'hFD);
        row_n = 8'hFD;
        wait_cyc(2);
        check("rev_r1", col_sense_n, 8'hFE);
        col_n = 8'h00;
        wait_cyc(2);
        check("fwd_two", row_sense_n, 8'h7D);
        send(8'hAA);
        check("aa_row", row_sense_n, 8'hFF);
        check("aa_col", col_sense_n, 8'hFF);

        row_n = 8'hFF;
        send(8'h1C); send(8'h26); send(8'h5A);
        col_n = 8'hFE;
        wait_cyc(2);
        check("ghost_none", row_sense_n, 8'hFD);
        send(8'h1D);
`ifdef KBD_GHOST_EN
        check("ghost_w", row_sense_n, 8'hF8);
`else
        check("ghost_w", row_sense_n, 8'hFD);
`endif
        check_int("end_ferr", err_pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
